// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and FSM encoding for seq_alu
// Purpose: 4-bit ALU opcode constants and the 2-bit FSM state type
//          used by seq_alu.
// Ports:   none (package).
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_MUL  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_DIVU = 4'b1011;
  localparam logic [3:0] ALU_REMU = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_BUSY = 2'd1,
    S_DIV_BUSY = 2'd2,
    S_DONE     = 2'd3
  } alu_state_e;

endpackage

// File: rtl/seq_div_unit.sv
// rtl/seq_div_unit.sv - iterative unsigned restoring divider
// Purpose: one quotient bit per cycle, MSB first, WIDTH steps after start.
// Ports:   clk_i/rst_i (async active-low) clock and reset
//          start_i            load dividend_i/divisor_i (divisor must be non-zero)
//          busy_o             iteration in progress
//          done_o             final step is being computed this cycle
//          quotient_o         quotient, valid while done_o
//          remainder_o        remainder, valid while done_o
module seq_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // quo_q doubles as the dividend shift register: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Results are the final step's next-state values so the caller can
  // register them on the same edge the last bit is resolved.
  assign busy_o      = busy_q;
  assign done_o      = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked execute-stage ALU with iterative MUL/DIVU/REMU
// Purpose: registered single-cycle ops, shift-add MUL, restoring DIVU/REMU.
// Ports:   clk_i/rst_i (async active-low) clock and reset
//          valid_i/ready_o    request handshake
//          data1_i/data2_i    operands A and B
//          ALUCtrl_i          4-bit opcode
//          valid_o/ready_i    result handshake
//          data_o             result, Zero_o operands-equal flag
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1,
  parameter bit          DIV_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [3:0]       ALUCtrl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  alu_state_e       state_q;
  logic             valid_q, ready_q, zero_q, rem_sel_q;
  logic [WIDTH-1:0] data_q;

  logic             accept, is_mul, is_div_op, div_iter;
  logic             mul_start, mul_last;
  logic [WIDTH-1:0] mul_res;
  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             slt;

  // ready_q is only ever high in IDLE, so it alone qualifies an accept.
  assign accept    = valid_i & ready_q;
  assign is_mul    = MUL_EN && (ALUCtrl_i == ALU_MUL);
  assign is_div_op = DIV_EN && ((ALUCtrl_i == ALU_DIVU) || (ALUCtrl_i == ALU_REMU));
  // Divide by zero is resolved in the single-cycle path.
  assign div_iter  = is_div_op && (data2_i != '0);
  assign mul_start = accept & is_mul;
  assign div_start = accept & div_iter;

  assign shamt = data2_i[SHW-1:0];
  assign slt   = $signed(data1_i) < $signed(data2_i);

  always_comb begin
    alu_res = data1_i;
    case (ALUCtrl_i)
      ALU_ADD:  alu_res = data1_i + data2_i;
      ALU_SUB:  alu_res = data1_i - data2_i;
      ALU_AND:  alu_res = data1_i & data2_i;
      ALU_OR:   alu_res = data1_i | data2_i;
      ALU_XOR:  alu_res = data1_i ^ data2_i;
      ALU_SLL:  alu_res = data1_i << shamt;
      ALU_SRL:  alu_res = data1_i >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(data1_i) >>> shamt);
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      // Only reached here for x/0 (or DIV_EN=0); REMU x/0 keeps data1_i.
      ALU_DIVU: alu_res = DIV_EN ? '1 : data1_i;
      default:  alu_res = data1_i;
    endcase
  end

  generate
    if (MUL_EN) begin : g_mul
      logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_d;
      logic [CW-1:0]    cnt_q;
      logic             busy_q;

      assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          mcand_q  <= '0;
          mplier_q <= '0;
          acc_q    <= '0;
          cnt_q    <= '0;
          busy_q   <= 1'b0;
        end else if (mul_start) begin
          mcand_q  <= data1_i;
          mplier_q <= data2_i;
          acc_q    <= '0;
          cnt_q    <= '0;
          busy_q   <= 1'b1;
        end else if (busy_q) begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            busy_q <= 1'b0;
          end
        end
      end

      assign mul_last = busy_q && (cnt_q == CW'(WIDTH - 1));
      assign mul_res  = acc_d;
    end else begin : g_no_mul
      assign mul_last = 1'b0;
      assign mul_res  = '0;
    end

    if (DIV_EN) begin : g_div
      seq_div_unit #(.WIDTH(WIDTH)) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start),
        .dividend_i  (data1_i),
        .divisor_i   (data2_i),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
      );
    end else begin : g_no_div
      assign div_busy = 1'b0;
      assign div_done = 1'b0;
      assign div_quo  = '0;
      assign div_rem  = '0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      data_q    <= '0;
      zero_q    <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            zero_q  <= (data1_i == data2_i);
            ready_q <= 1'b0;
            if (is_mul) begin
              state_q <= S_MUL_BUSY;
            end else if (div_iter) begin
              rem_sel_q <= (ALUCtrl_i == ALU_REMU);
              state_q   <= S_DIV_BUSY;
            end else begin
              data_q  <= alu_res;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_MUL_BUSY: begin
          if (mul_last) begin
            data_q  <= mul_res;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DIV_BUSY: begin
          if (div_busy && div_done) begin
            data_q  <= rem_sel_q ? div_rem : div_quo;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // No accept on the release edge: one bubble between ops.
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign Zero_o  = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu against an arithmetic model
module tb_seq_alu;

  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [W-1:0]  data1_i = '0;
  logic [W-1:0]  data2_i = '0;
  logic [3:0]    ALUCtrl_i = 4'd0;
  logic          ready_o, valid_o, Zero_o;
  logic [W-1:0]  data_o;

  int total = 0;
  int bad = 0;

  seq_alu #(.WIDTH(W), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .ALUCtrl_i (ALUCtrl_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .Zero_o    (Zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint unsigned pa, pb, p;
    int sh;
    sh = int'(b[4:0]);
    pa = a;
    pb = b;
    case (op)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return a & b;
      4'd4:  return a | b;
      4'd5:  return a ^ b;
      4'd6:  begin p = pa * pb; return p[W-1:0]; end
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return W'($signed(a) >>> sh);
      4'd10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: return (b == 0) ? a : a % b;
      default: return a;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] b);
    if (op == 4'd6) return W + 1;
    if ((op == 4'd11 || op == 4'd12) && b != 0) return W + 1;
    return 1;
  endfunction

  // Issue one op, check latency/result/Zero, hold back-pressure for
  // 'stall' cycles with valid_i noise, then consume and check the bubble.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int stall);
    logic [W-1:0] exp;
    int           exp_lat, lat;
    bit           busy_ready;
    exp     = model(op, a, b);
    exp_lat = model_lat(op, b);
    @(negedge clk_i);
    check({tag, ".ready_idle"}, ready_o, 1);
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    ready_i   = 1'b0;
    @(posedge clk_i);
    #1;
    valid_i   = 1'b0;
    data1_i   = $urandom;
    data2_i   = $urandom;
    ALUCtrl_i = 4'($urandom);
    lat = 1;
    busy_ready = 1'b0;
    while (!valid_o && lat <= 100) begin
      if (ready_o) busy_ready = 1'b1;
      @(posedge clk_i);
      #1;
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".data"}, data_o, exp);
    check({tag, ".zero"}, Zero_o, (a == b));
    if (exp_lat > 1) check({tag, ".busy_ready"}, busy_ready, 0);
    for (int i = 0; i < stall; i++) begin
      valid_i   = 1'($urandom);
      data1_i   = $urandom;
      data2_i   = $urandom;
      ALUCtrl_i = 4'($urandom);
      @(posedge clk_i);
      #1;
      check({tag, ".hold_valid"}, valid_o, 1);
      check({tag, ".hold_data"}, data_o, exp);
      check({tag, ".hold_zero"}, Zero_o, (a == b));
      check({tag, ".hold_ready"}, ready_o, 0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    check({tag, ".consumed"}, valid_o, 0);
    check({tag, ".ready_back"}, ready_o, 1);
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    bit           saw_valid;

    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst.valid", valid_o, 0);
    check("rst.data", data_o, 0);
    check("rst.zero", Zero_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("rst.ready", ready_o, 1);

    do_op("add_ovf", 4'd1, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    do_op("sub_eq",  4'd2, 32'd5, 32'd5, 0);
    do_op("mul_big", 4'd6, 32'h0001_0000, 32'h0001_0001, 0);
    do_op("mul_small", 4'd6, 32'd123, 32'd456, 1);
    do_op("divu",    4'd11, 32'd100, 32'd7, 0);
    do_op("remu",    4'd12, 32'd100, 32'd7, 0);
    do_op("divu0",   4'd11, 32'h1234, 32'd0, 0);
    do_op("remu0",   4'd12, 32'h1234, 32'd0, 0);
    do_op("sra",     4'd9, 32'h8000_0000, 32'd4, 0);
    do_op("slt",     4'd10, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("dflt",    4'd15, 32'h0000_ABCD, 32'h5555_0000, 0);
    do_op("xor_bp",  4'd5, 32'hF0F0_1234, 32'h0FF0_4321, 5);

    // Reset in the middle of a multiply.
    @(negedge clk_i);
    valid_i   = 1'b1;
    ALUCtrl_i = 4'd6;
    data1_i   = 32'hDEAD_BEEF;
    data2_i   = 32'h1234_5678;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("midrst.valid", valid_o, 0);
    check("midrst.data", data_o, 0);
    check("midrst.zero", Zero_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("midrst.ready", ready_o, 1);
    saw_valid = 1'b0;
    repeat (W + 4) begin
      @(posedge clk_i);
      #1;
      if (valid_o) saw_valid = 1'b1;
    end
    check("midrst.no_partial", saw_valid, 0);
    do_op("post_rst_add", 4'd1, 32'd2, 32'd3, 0);

    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom % 8)
        0: b = '0;
        1: b = a;
        2: b = $urandom % 64;
        default: b = $urandom;
      endcase
      if ($urandom % 4 == 0) a = $urandom % 256;
      do_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
